axi_read_arbiter: RTL and testbench
===================================

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 The block SHALL have one clock, system_clk, and a synchronous active-low reset, system_rst_n; all state SHALL update on the rising edge of system_clk.
REQ-002 Parameters, as name, default and meaning:
- NUM_REQ, 3, number of requesters (feature, weight, video readback).
- ADDR_W, 32, AXI address width.
- DATA_W, 512, AXI data width.
REQ-003 Ports, as name, direction, width and meaning:
- system_clk  in  1  clock.
- system_rst_n  in  1  sync reset, active low.
- req_valid  in  NUM_REQ  per-requester burst request.
- req_addr  in  NUM_REQ*ADDR_W  byte address, 64-byte aligned.
- req_len  in  NUM_REQ*8  AXI arlen (beats minus 1).
- req_ready  out  NUM_REQ  request accepted.
- rd_valid  out  NUM_REQ  beat valid for the granted requester.
- rd_ready  in  NUM_REQ  requester accepts the beat.
- rd_data  out  DATA_W  shared return data.
- rd_last  out  1  last beat of the burst.
- m00_axi_araddr  out  ADDR_W  AR address.
- m00_axi_arlen  out  8  AR length.
- m00_axi_arsize  out  3  AR size, constant 3'd6.
- m00_axi_arburst  out  2  AR burst, constant 2'b01 (INCR).
- m00_axi_arvalid  out  1  AR valid.
- m00_axi_arready  in  1  AR ready.
- m00_axi_rdata  in  DATA_W  R data.
- m00_axi_rresp  in  2  R response.
- m00_axi_rlast  in  1  R last.
- m00_axi_rvalid  in  1  R valid.
- m00_axi_rready  out  1  R ready.
- busy  out  1  state is not IDLE.
- rresp_err  out  1  sticky: a nonzero rresp was seen.

Function
REQ-004 The FSM SHALL have three states: IDLE, ADDR and DATA; exactly one burst SHALL be outstanding at a time.
REQ-005 IDLE: if any req_valid is high, the block SHALL register grant = the first set bit searching upward from (last_grant+1) mod NUM_REQ, latch that requester's addr and len, and go to ADDR on the next edge. With no request it SHALL stay in IDLE.
REQ-006 ADDR: m00_axi_arvalid=1 with the latched araddr and arlen; the AR fields SHALL be held stable until m00_axi_arready.
REQ-007 In the cycle where arvalid and arready are both high, req_ready[grant] SHALL be 1 for that cycle only, and the FSM SHALL move to DATA.
REQ-008 req_ready SHALL be 0 for every requester in every other cycle.
REQ-009 First arvalid SHALL occur exactly 1 cycle after req_valid is sampled in IDLE.
REQ-010 DATA: the R channel SHALL be connected combinationally to the granted requester:
- rd_valid[grant]=m00_axi_rvalid;
- m00_axi_rready=rd_ready[grant];
- rd_data=m00_axi_rdata;
- rd_last=m00_axi_rlast;
- all other rd_valid bits SHALL be 0.
REQ-011 In IDLE and ADDR, m00_axi_rready SHALL be 0 and all rd_valid bits SHALL be 0.
REQ-012 On a DATA beat with rvalid, rready and rlast all high, the block SHALL set last_grant=grant and return to IDLE.
REQ-013 Re-arbitration SHALL take one IDLE cycle, giving a minimum 2-cycle gap between bursts.
REQ-014 Fairness: a requester that holds req_valid high SHALL be granted within NUM_REQ bursts.
REQ-015 If a requester deasserts req_valid in the same cycle the grant is taken, the request SHALL still be serviced; the grant is never retracted.
REQ-016 rresp_err SHALL be set on any beat with rvalid, rready and rresp!=0. It SHALL be cleared only by reset, and data SHALL still be forwarded on that beat.
REQ-017 The block SHALL NOT split or check 4KB-boundary crossings; keeping bursts within a 4KB boundary is the requester's responsibility.

Reset
REQ-018 While system_rst_n=0 at a clock edge, the block SHALL set:
- state = IDLE;
- last_grant = NUM_REQ-1, so requester 0 wins first;
- arvalid, rready, req_ready, rd_valid, rresp_err, busy all = 0;
- latched addr and len = 0.
REQ-019 A reset asserted mid-burst SHALL abort immediately with no further beats forwarded; the AXI slave shares the same reset.

Structure
REQ-020 The AXI constants (ARSIZE_64B=3'd6, BURST_INCR=2'b01) and the state encoding SHALL be placed in the shared parameters include.
REQ-021 The round-robin priority picker SHALL be a sub-module, rr_picker (inputs: request vector and last_grant; output: one-hot/index grant and a valid flag).

Verification
REQ-022 Single request: req_valid[1] with addr 0x1000, len 3 -> araddr=0x1000, arlen=3 one cycle later; 4 beats appear only on rd_valid[1]; rd_last on beat 4; busy drops one cycle after rd_last.
REQ-023 All three requesters held continuously -> grant order 0,1,2,0,1,2 over 6 bursts; no requester is starved.
REQ-024 arready delayed 5 cycles -> arvalid, araddr and arlen are stable for all 6 cycles; req_ready[grant] pulses exactly once.
REQ-025 rd_ready toggled 50% randomly over a len=15 burst -> exactly 16 beats transferred, data matches RAM contents, no beat lost or duplicated.
REQ-026 rresp=2'b10 on beat 2 -> rresp_err=1 from the next cycle onward and stays 1 until reset; the burst still completes.
REQ-027 system_rst_n pulled low during beat 3 of 8 -> the next cycle shows IDLE with all outputs 0; after release, a fresh request is granted to requester 0 first.

Source files
------------

// File: rtl/axi_read_arbiter_pkg.sv
// axi_read_arbiter_pkg: shared FSM encoding and fixed AXI read-address constants
package axi_read_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  localparam logic [2:0] ARSIZE_64B = 3'd6;
  localparam logic [1:0] BURST_INCR = 2'b01;
endpackage

// File: rtl/axi_read_arbiter_rr_picker.sv
// rr_picker: round-robin pick of the first request at or after last_i+1 (mod N)
module rr_picker #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);
  logic [IW-1:0] c;
  always_comb begin
    c = '0;
    idx_o = '0;
    valid_o = |req_i;
    // walk from farthest to nearest so the nearest requester wins
    for (int i = N; i >= 1; i--) begin
      c = IW'((int'(last_i) + i) % N);
      if (req_i[c]) idx_o = c;
    end
  end
endmodule

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: round-robin arbiter sharing one AXI read master, one burst at a time
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 512
) (
  input  logic                      system_clk,
  input  logic                      system_rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]      req_len,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rd_valid,
  input  logic [NUM_REQ-1:0]        rd_ready,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_last,
  output logic [ADDR_W-1:0]         m00_axi_araddr,
  output logic [7:0]                m00_axi_arlen,
  output logic [2:0]                m00_axi_arsize,
  output logic [1:0]                m00_axi_arburst,
  output logic                      m00_axi_arvalid,
  input  logic                      m00_axi_arready,
  input  logic [DATA_W-1:0]         m00_axi_rdata,
  input  logic [1:0]                m00_axi_rresp,
  input  logic                      m00_axi_rlast,
  input  logic                      m00_axi_rvalid,
  output logic                      m00_axi_rready,
  output logic                      busy,
  output logic                      rresp_err
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  state_t state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, last_q, last_d, pick_idx;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0] len_q, len_d;
  logic err_q, err_d, pick_valid, r_hs;
  rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req_i  (req_valid),
    .last_i (last_q),
    .idx_o  (pick_idx),
    .valid_o(pick_valid)
  );
  assign r_hs = state_q == DATA && m00_axi_rvalid && rd_ready[grant_q];
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    addr_d = addr_q;
    len_d = len_q;
    err_d = err_q | (r_hs && m00_axi_rresp != 2'b00);
    req_ready = '0;
    rd_valid = '0;
    m00_axi_arvalid = state_q == ADDR;
    m00_axi_rready = 1'b0;
    case (state_q)
      IDLE: if (pick_valid) begin
        grant_d = pick_idx;
        addr_d = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
        len_d = req_len[int'(pick_idx)*8 +: 8];
        state_d = ADDR;
      end
      ADDR: if (m00_axi_arready) begin
        req_ready[grant_q] = 1'b1;
        state_d = DATA;
      end
      DATA: begin
        rd_valid[grant_q] = m00_axi_rvalid;
        m00_axi_rready = rd_ready[grant_q];
        if (r_hs && m00_axi_rlast) begin
          last_d = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign rd_data = state_q == DATA ? m00_axi_rdata : '0;
  assign rd_last = state_q == DATA && m00_axi_rlast;
  assign busy = state_q != IDLE;
  assign rresp_err = err_q;
  assign m00_axi_araddr = addr_q;
  assign m00_axi_arlen = len_q;
  assign m00_axi_arsize = ARSIZE_64B;
  assign m00_axi_arburst = BURST_INCR;
  always_ff @(posedge system_clk) begin
    if (!system_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= IW'(NUM_REQ - 1);
      addr_q <= '0;
      len_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      addr_q <= addr_d;
      len_q <= len_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed vector table plus corner-case sequences against an AXI slave model
module tb_axi_read_arbiter;
  localparam int N = 3, AW = 32, DW = 512;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [N-1:0] req_valid = '0, req_ready, rd_valid, rd_ready = '1;
  logic [AW-1:0] a [N];
  logic [N*AW-1:0] req_addr;
  logic [7:0] len8 = '0;
  logic [N*8-1:0] req_len;
  assign req_addr = {a[2], a[1], a[0]};
  assign req_len = {3{len8}};
  logic [DW-1:0] rd_data, rdata = '0;
  logic rd_last, arvalid, rready, busy, rresp_err;
  logic arready = 0, rlast = 0, rvalid = 0;
  logic [1:0] rresp = '0, arburst;
  logic [2:0] arsize;
  logic [AW-1:0] araddr;
  logic [7:0] arlen;
  int tot = 0, bad = 0;
  int ar_wait = 0, err_beat = -1;
  bit rand_mode = 0;
  typedef struct {logic [N-1:0] rv; logic [DW-1:0] d; logic l;} beat_t;
  typedef struct {logic [N-1:0] mask; logic [7:0] len; int g; logic [AW-1:0] addr;} row_t;
  beat_t bq[$];
  row_t rows[10];

  axi_read_arbiter dut (
    .system_clk(clk), .system_rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .m00_axi_araddr(araddr), .m00_axi_arlen(arlen), .m00_axi_arsize(arsize),
    .m00_axi_arburst(arburst), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
    .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rlast(rlast),
    .m00_axi_rvalid(rvalid), .m00_axi_rready(rready),
    .busy(busy), .rresp_err(rresp_err)
  );

  function automatic logic [DW-1:0] bdata(input logic [AW-1:0] ad, input int k);
    logic [31:0] w;
    w = ad + 32'(k) * 32'd64;
    return {16{w}};
  endfunction

  task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // AXI slave model: handshakes sampled at negedge, state advanced just after posedge
  always begin : slave
    logic ar_hs, r_hs, rs, arv;
    logic s_busy;
    logic [AW-1:0] s_addr, cap_addr;
    logic [7:0] s_len, cap_len;
    int s_beat, ar_cnt;
    @(negedge clk);
    ar_hs = arvalid && arready;
    r_hs = rvalid && rready;
    rs = !rst_n;
    arv = arvalid;
    cap_addr = araddr;
    cap_len = arlen;
    if (r_hs) bq.push_back('{rd_valid, rd_data, rd_last});
    @(posedge clk);
    #1;
    if (rs) begin
      s_busy = 0;
      ar_cnt = 0;
      s_beat = 0;
      s_len = 0;
      s_addr = 0;
    end else begin
      if (ar_hs) begin
        s_busy = 1;
        s_addr = cap_addr;
        s_len = cap_len;
        s_beat = 0;
        ar_cnt = 0;
      end else if (arv && !s_busy) ar_cnt++;
      if (r_hs) begin
        if (s_beat == int'(s_len)) s_busy = 0;
        else s_beat++;
      end
    end
    arready = !s_busy && ar_cnt >= ar_wait;
    rvalid = s_busy;
    rdata = s_busy ? bdata(s_addr, s_beat) : '0;
    rlast = s_busy && s_beat == int'(s_len);
    rresp = (s_busy && s_beat == err_beat) ? 2'b10 : 2'b00;
    rd_ready = rand_mode ? 3'($urandom) : 3'b111;
  end

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    chk("idle", busy, 0);
  endtask

  task automatic check_burst(input int g, input logic [AW-1:0] ad, input logic [7:0] len);
    chk("nbeats", bq.size(), int'(len) + 1);
    foreach (bq[k]) begin
      chk("beat_rv", bq[k].rv, 3'b001 << g);
      chk("beat_data", bq[k].d, bdata(ad, k));
      chk("beat_last", bq[k].l, k == int'(len));
    end
    bq.delete();
  endtask

  task automatic run_row(input row_t r);
    int k;
    step();
    req_valid = r.mask;
    len8 = r.len;
    @(negedge clk);
    chk("arv_pre", arvalid, 0);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("arv", arvalid, 1);
    chk("araddr", araddr, r.addr);
    chk("arlen", arlen, r.len);
    chk("grant", req_ready, 3'b001 << r.g);
    k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("busy_drop", k, int'(r.len) + 2);
    check_burst(r.g, r.addr, r.len);
  endtask

  initial begin
    int n, n_av, n_rr;
    bit found;
    a[0] = 32'h0001_0000;
    a[1] = 32'h0000_1000;
    a[2] = 32'h0003_0080;
    rows[0] = '{3'b010, 8'd3, 1, 32'h0000_1000};
    rows[1] = '{3'b111, 8'd0, 2, 32'h0003_0080};
    rows[2] = '{3'b111, 8'd1, 0, 32'h0001_0000};
    rows[3] = '{3'b111, 8'd2, 1, 32'h0000_1000};
    rows[4] = '{3'b101, 8'd3, 2, 32'h0003_0080};
    rows[5] = '{3'b101, 8'd0, 0, 32'h0001_0000};
    rows[6] = '{3'b101, 8'd7, 2, 32'h0003_0080};
    rows[7] = '{3'b011, 8'd1, 0, 32'h0001_0000};
    rows[8] = '{3'b011, 8'd0, 1, 32'h0000_1000};
    rows[9] = '{3'b100, 8'd2, 2, 32'h0003_0080};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ctl", {arvalid, rready, rd_last, rresp_err}, 0);
    chk("rst_vec", {req_ready, rd_valid}, 0);
    chk("rst_ar", {araddr, arlen}, 0);
    chk("arsize", arsize, 3'd6);
    chk("arburst", arburst, 2'b01);
    step();
    rst_n = 1;
    foreach (rows[r]) run_row(rows[r]);

    ar_wait = 5;
    step();
    req_valid = 3'b001;
    len8 = 8'd1;
    step();
    req_valid = '0;
    n_av = 0;
    n_rr = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arvalid) begin
        n_av++;
        chk("ar_hold_addr", araddr, a[0]);
        chk("ar_hold_len", arlen, 8'd1);
      end
      if (req_ready != '0) begin
        n_rr++;
        chk("ar_rr_bit", req_ready, 3'b001);
      end
    end
    chk("ar_cycles", n_av, 6);
    chk("ar_rr_pulses", n_rr, 1);
    wait_idle();
    check_burst(0, a[0], 8'd1);
    ar_wait = 0;

    rand_mode = 1;
    step();
    req_valid = 3'b010;
    len8 = 8'd15;
    step();
    req_valid = '0;
    @(negedge clk);
    wait_idle();
    rand_mode = 0;
    check_burst(1, a[1], 8'd15);

    err_beat = 1;
    step();
    req_valid = 3'b100;
    len8 = 8'd3;
    step();
    req_valid = '0;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rvalid && rready && rresp != 2'b00) begin
        found = 1;
        break;
      end
    end
    chk("err_seen", found, 1);
    chk("err_before", rresp_err, 0);
    @(negedge clk);
    chk("err_after", rresp_err, 1);
    wait_idle();
    check_burst(2, a[2], 8'd3);
    chk("err_sticky", rresp_err, 1);
    err_beat = -1;

    step();
    req_valid = 3'b001;
    len8 = 8'd7;
    step();
    req_valid = '0;
    n = 0;
    for (int i = 0; i < 30 && n < 2; i++) begin
      @(negedge clk);
      if (rvalid && rready) n++;
    end
    chk("pre_rst_beats", n, 2);
    step();
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ctl", {arvalid, rready, rd_last, rresp_err}, 0);
    chk("mid_rst_vec", {req_ready, rd_valid}, 0);
    chk("mid_rst_ar", {araddr, arlen}, 0);
    chk("mid_rst_data", rd_data, 0);
    step();
    rst_n = 1;
    bq.delete();

    step();
    req_valid = 3'b111;
    len8 = 8'd0;
    n = 0;
    for (int i = 0; i < 200 && n < 6; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        chk("rr_order", req_ready, 3'b001 << (n % 3));
        n++;
      end
    end
    req_valid = '0;
    chk("rr_count", n, 6);
    wait_idle();
    bq.delete();

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
